// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state encoding, default sizes and small opcode decode helpers.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } mdState_e;

  function automatic logic isValidOp(input logic [2:0] op);
    return op <= MD_DIVU;
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_addsub.sv
// WIDTH+1-bit adder/subtractor shared by the multiply and divide loops.
// borrow is meaningful only when sub=1 and means a < b.
module md_addsub import md_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] sum,
  output logic           borrow
);

  logic [WIDTH+1:0] full;

  // Two's-complement subtract as a + ~b + 1; carry-out low means borrow.
  always_comb begin
    full   = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{(WIDTH+1){1'b0}}, sub};
    sum    = full[WIDTH:0];
    borrow = sub & ~full[WIDTH+1];
  end

endmodule

// File: rtl/md_sequencer.sv
// Iterative multiply/divide unit for the E stage. Owns HI/LO, runs a radix-2
// shift-add multiply or restoring divide over one shared adder, and services
// mthi/mtlo while idle.
//
// Handshake: start is a one-cycle request accepted only in IDLE with a valid
// MDOp; busy rises on the accepting edge and falls on the edge that writes
// HI/LO, so a request is in flight exactly while busy=1. Requests and
// mthi/mtlo seen while busy are ignored.
module md_sequencer import md_pkg::*; #(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] WD,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  mdState_e           state, nextState;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;        // {rem / product high, quotient / product low}
  logic [WIDTH-1:0]   opA, opB;   // raw operands at start, magnitudes after PREP
  logic               opSigned, opDiv;
  logic               negRes, negRem, divZero;

  logic [WIDTH:0]     addA, addB, addSum;
  logic               addSub, addBorrow;
  logic [2*WIDTH-1:0] fixProd;
  logic [WIDTH-1:0]   fixQuo, fixRem;
  logic               ioWrite;

  md_addsub #(.WIDTH(WIDTH)) uAddSub (
    .a      (addA),
    .b      (addB),
    .sub    (addSub),
    .sum    (addSum),
    .borrow (addBorrow)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  // Next-state logic and the idle-only mthi/mtlo enable.
  always_comb begin
    nextState = state;
    ioWrite   = 1'b0;
    case (state)
      S_IDLE: begin
        ioWrite = !start;
        if (start && isValidOp(MDOp)) nextState = S_PREP;
      end
      S_PREP: nextState = S_RUN;
      S_RUN:  if (count == CW'(ITER - 1)) nextState = S_FIX;
      S_FIX:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  // Adder operands: conditional add of the multiplicand, or trial subtract of
  // the divisor from the remainder shifted left by one dividend bit.
  always_comb begin
    if (opDiv) begin
      addA   = acc[2*WIDTH-1:WIDTH-1];
      addB   = {1'b0, opB};
      addSub = 1'b1;
    end else begin
      addA   = {1'b0, acc[2*WIDTH-1:WIDTH]};
      addB   = acc[0] ? {1'b0, opB} : '0;
      addSub = 1'b0;
    end
  end

  // Sign correction applied to the magnitude results in FIX.
  always_comb begin
    fixProd = negRes ? -acc : acc;
    fixQuo  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fixRem  = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Datapath: operand capture, iteration, result write-back and mthi/mtlo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      acc      <= '0;
      opA      <= '0;
      opB      <= '0;
      opSigned <= 1'b0;
      opDiv    <= 1'b0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      divZero  <= 1'b0;
    end else begin
      busy <= (nextState != S_IDLE);
      case (state)
        S_IDLE: begin
          if (nextState == S_PREP) begin
            opA      <= A;
            opB      <= B;
            opSigned <= isSignedOp(MDOp);
            opDiv    <= isDivOp(MDOp);
          end else if (ioWrite) begin
            if (mthi) hi <= WD;
            if (mtlo) lo <= WD;
          end
        end
        S_PREP: begin
          acc     <= {{WIDTH{1'b0}}, ((opSigned && opA[WIDTH-1]) ? -opA : opA)};
          opB     <= (opSigned && opB[WIDTH-1]) ? -opB : opB;
          negRes  <= opSigned && (opA[WIDTH-1] ^ opB[WIDTH-1]);
          negRem  <= opSigned && opA[WIDTH-1];
          divZero <= (opB == '0);
          count   <= '0;
        end
        S_RUN: begin
          if (opDiv)
            acc <= {(addBorrow ? acc[2*WIDTH-2:WIDTH-1] : addSum[WIDTH-1:0]),
                    acc[WIDTH-2:0], ~addBorrow};
          else
            acc <= {addSum, acc[WIDTH-1:1]};
          count <= count + CW'(1);
        end
        S_FIX: begin
          if (!opDiv) begin
            {hi, lo} <= fixProd;
          end else if (!divZero) begin
            lo <= fixQuo;
            hi <= fixRem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: hand-computed products, quotients and
// remainders, busy length, HI/LO hold during an operation, mthi/mtlo rules
// and asynchronous reset mid-operation.
module tb_md_sequencer;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = '0, B = '0, WD = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int testCount = 0;
  int failCount = 0;

  // Clock.
  always #5 clk = ~clk;

  md_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .WD    (WD),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op and follow it until busy drops. pokeKind 1 pulses start,
  // pokeKind 2 pulses mtlo, on the fifth busy cycle.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int pokeKind, output int cycles, output bit held);
    logic [31:0] hi0, lo0;
    @(negedge clk);
    hi0 = hi;
    lo0 = lo;
    start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; MDOp = 3'($urandom_range(0, 7));
    cycles = 0;
    held = 1'b1;
    while (busy && cycles < 100) begin
      cycles++;
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      if (cycles == 5 && pokeKind == 1) begin
        start = 1'b1; MDOp = MD_MULTU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
      end else if (cycles == 5 && pokeKind == 2) begin
        mtlo = 1'b1; WD = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; mtlo = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    mtlo = 1'b0;
  endtask

  task automatic checkOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi,
                         input logic [31:0] expLo, input int pokeKind);
    int cycles;
    bit held;
    runOp(op, a, b, pokeKind, cycles, held);
    checkVal({tag, "_busy"}, 64'(cycles), 64'd34);
    checkVal({tag, "_hold"}, 64'(held), 64'd1);
    checkVal({tag, "_hilo"}, {hi, lo}, {expHi, expLo});
  endtask

  task automatic moveTo(input bit doHi, input bit doLo, input logic [31:0] data);
    @(negedge clk);
    mthi = doHi; mtlo = doLo; WD = data;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; WD = $urandom;
  endtask

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    int cycles;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkVal("reset_busy", 64'(busy), 64'd0);
    checkVal("reset_hilo", {hi, lo}, 64'd0);
    checkVal("reset_state", 64'(dut.state), 64'(S_IDLE));

    checkOp("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    checkOp("mult_neg_a", MD_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    checkOp("mult_neg_b", MD_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    checkOp("mult_neg_both", MD_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0015, 0);
    checkOp("div_neg_a", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    checkOp("div_neg_b", MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    checkOp("div_neg_both", MD_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 0);
    checkOp("divu_small", MD_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 0);
    checkOp("divu_max", MD_DIVU, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 0);
    checkOp("div_min_neg1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    checkOp("divu_big_div", MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 0);

    moveTo(1'b1, 1'b0, 32'h0000_1234);
    checkVal("mthi_only", {hi, lo}, {32'h0000_1234, 32'h0000_0000});
    moveTo(1'b0, 1'b1, 32'h0000_5678);
    checkVal("mtlo_only", {hi, lo}, {32'h0000_1234, 32'h0000_5678});
    checkOp("div_by_zero", MD_DIV, 32'h0000_0042, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 0);
    checkOp("divu_by_zero", MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 0);
    moveTo(1'b1, 1'b1, 32'h0000_CAFE);
    checkVal("mthi_mtlo_both", {hi, lo}, {32'h0000_CAFE, 32'h0000_CAFE});

    checkOp("mtlo_while_busy", MD_MULT, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 2);
    checkOp("start_while_busy", MD_MULT, 32'h0000_0004, 32'h0000_0005, 32'h0000_0000, 32'h0000_0014, 1);

    // Invalid opcode is ignored entirely.
    @(negedge clk);
    start = 1'b1; MDOp = 3'd5; A = 32'd3; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    checkVal("invalid_op_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    checkVal("invalid_op_hilo", {64'(busy), hi, lo}, {64'd0, 32'h0000_0000, 32'h0000_0014});

    // start and mthi together: the write is dropped.
    moveTo(1'b1, 1'b0, 32'h0000_1111);
    @(negedge clk);
    start = 1'b1; MDOp = MD_MULTU; A = 32'd5; B = 32'd5; mthi = 1'b1; WD = 32'h0000_AAAA;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    checkVal("start_mthi_hi", {hi, lo}, {32'h0000_1111, 32'h0000_0014});
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    checkVal("start_mthi_result", {hi, lo}, {32'h0000_0000, 32'h0000_0019});

    // Asynchronous reset on the tenth busy cycle of a mult.
    moveTo(1'b1, 1'b0, 32'h0000_7777);
    @(negedge clk);
    start = 1'b1; MDOp = MD_MULT; A = 32'd9; B = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkVal("pre_reset_busy", {64'(busy), hi, lo}, {64'd1, 32'h0000_7777, 32'h0000_0019});
    reset = 1'b1;
    #1;
    checkVal("mid_reset", {64'(busy), hi, lo}, {64'd0, 64'd0});
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkVal("after_abort", {64'(busy), hi, lo}, {64'd0, 64'd0});

    checkOp("multu_post_reset", MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
